// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_ctrl
// Purpose  : Multi-cycle sequencer for the R.O.E ALU datapath. Accepts one
//            9-bit instruction over a valid/ready handshake, steps
//            DECODE -> EXEC -> WB and drives the ALU source select, operand
//            fields, destination register and write enable. A hardware
//            repeat (REP) iterates an increment-by-one write up to 15 times
//            without refetching.
// Ports    : clk, rst_n (async active-low)
//            instr_valid, instr[8:0]  -> instruction handshake in
//            instr_ready              <- high only in IDLE
//            alu_src[1:0]             <- 00 inc+1, 01 imm, 10 register read0
//            imm4[3:0], inc3[2:0]     <- ALU operand fields
//            rd_addr[1:0], reg_we     <- register-file write port control
//            busy, done, err          <- status (done/err are 1-cycle pulses)
// Config   : ALU_SEQ_ILLEGAL_TRAP_EN - when defined, opcode 1xx pulses err
//            together with done; otherwise 1xx is a NOP and err is tied 0.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  input  logic [8:0] instr,
  output logic       instr_ready,
  output logic [1:0] alu_src,
  output logic [3:0] imm4,
  output logic [2:0] inc3,
  output logic [1:0] rd_addr,
  output logic       reg_we,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  localparam logic [1:0] SRC_INC = 2'b00;
  localparam logic [1:0] SRC_IMM = 2'b01;
  localparam logic [1:0] SRC_REG = 2'b10;

  state_t     state;
  logic [3:0] rep_cnt;  // remaining REP iterations
  logic       is_rep;   // latched: current instruction is REP
  logic       skip;     // latched: DECODE returns straight to IDLE
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  logic       err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Operand fields are decoded from instr at the accepting edge so that they
  // are already valid during the DECODE cycle; they then hold until the
  // instruction retires, after which they fall back to their idle values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      instr_ready <= 1'b1;
      busy        <= 1'b0;
      alu_src     <= SRC_REG;
      imm4        <= 4'd0;
      inc3        <= 3'd0;
      rd_addr     <= 2'd0;
      reg_we      <= 1'b0;
      done        <= 1'b0;
      rep_cnt     <= 4'd0;
      is_rep      <= 1'b0;
      skip        <= 1'b0;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
      err_q       <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low every cycle.
      reg_we <= 1'b0;
      done   <= 1'b0;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
      err_q  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (instr_valid) begin
            state       <= DECODE;
            instr_ready <= 1'b0;
            busy        <= 1'b1;
            rd_addr     <= instr[5:4];
            is_rep      <= 1'b0;
            skip        <= 1'b0;
            rep_cnt     <= 4'd0;
            case (instr[8:6])
              3'b000: begin
                alu_src <= SRC_IMM;
                imm4    <= instr[3:0];
              end
              3'b001: begin
                alu_src <= SRC_INC;
                inc3    <= instr[2:0];
              end
              3'b010: begin
                alu_src <= SRC_REG;
              end
              3'b011: begin
                alu_src <= SRC_INC;
                inc3    <= 3'd0;
                is_rep  <= 1'b1;
                rep_cnt <= instr[3:0];
                // A zero-count repeat retires in DECODE with no write.
                if (instr[3:0] == 4'd0) begin
                  done <= 1'b1;
                  skip <= 1'b1;
                end
              end
              default: begin
                // Opcode 1xx: no write, retire in DECODE.
                alu_src <= SRC_REG;
                done    <= 1'b1;
                skip    <= 1'b1;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
                err_q   <= 1'b1;
`endif
              end
            endcase
          end
        end

        DECODE: begin
          if (skip) begin
            state       <= IDLE;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            alu_src     <= SRC_REG;
            imm4        <= 4'd0;
            inc3        <= 3'd0;
            rd_addr     <= 2'd0;
          end else begin
            state <= EXEC;
          end
        end

        EXEC: begin
          // reg_we/done are registered on entry to WB so they are Moore
          // outputs of the WB cycle. For REP, done marks the final write.
          state  <= WB;
          reg_we <= 1'b1;
          if (!is_rep || rep_cnt == 4'd1) begin
            done <= 1'b1;
          end
        end

        WB: begin
          if (is_rep) begin
            rep_cnt <= rep_cnt - 4'd1;
          end
          if (!is_rep || rep_cnt == 4'd1) begin
            state       <= IDLE;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            alu_src     <= SRC_REG;
            imm4        <= 4'd0;
            inc3        <= 3'd0;
            rd_addr     <= 2'd0;
          end else begin
            state <= EXEC;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq_ctrl
// Purpose  : Directed self-checking bench for alu_seq_ctrl. Cycle numbers
//            below count from the accepting cycle (cycle 0); outputs are
//            sampled on the falling edge of each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       instr_valid;
  logic [8:0] instr;
  logic       instr_ready;
  logic [1:0] alu_src;
  logic [3:0] imm4;
  logic [2:0] inc3;
  logic [1:0] rd_addr;
  logic       reg_we;
  logic       busy;
  logic       done;
  logic       err;

  int checks;
  int errors;

  alu_seq_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .alu_src     (alu_src),
    .imm4        (imm4),
    .inc3        (inc3),
    .rd_addr     (rd_addr),
    .reg_we      (reg_we),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one instruction for one accepting edge; returns just after the
  // edge with valid dropped and instr scrambled, so cycle 1 is the next negedge.
  task automatic issue(input logic [8:0] ins);
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = ins;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = 9'h1FF;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", instr_ready); end
    checks++; if (alu_src !== 2'b10) begin errors++; $display("FAIL reset_alu_src: got %b expected 10", alu_src); end
    checks++; if (imm4 !== 4'd0 || inc3 !== 3'd0 || rd_addr !== 2'd0) begin errors++; $display("FAIL reset_fields: got imm4=%0d inc3=%0d rd=%0d expected 0/0/0", imm4, inc3, rd_addr); end
    checks++; if ({reg_we, busy, done, err} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got we/busy/done/err=%b expected 0000", {reg_we, busy, done, err}); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (instr_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_release: got ready=%b busy=%b expected 1/0", instr_ready, busy); end
  endtask

  task automatic test_addi();
    issue(9'b000_10_0111);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++; if (alu_src !== ((c <= 3) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL addi_src c%0d: got %b expected %b", c, alu_src, (c <= 3) ? 2'b01 : 2'b10); end
      checks++; if (imm4 !== ((c <= 3) ? 4'd7 : 4'd0)) begin errors++; $display("FAIL addi_imm c%0d: got %0d expected %0d", c, imm4, (c <= 3) ? 7 : 0); end
      checks++; if (reg_we !== (c == 3) || done !== (c == 3)) begin errors++; $display("FAIL addi_we_done c%0d: got we=%b done=%b expected %b", c, reg_we, done, c == 3); end
      checks++; if (instr_ready !== (c == 4) || busy !== (c != 4)) begin errors++; $display("FAIL addi_ready c%0d: got ready=%b busy=%b expected %b/%b", c, instr_ready, busy, c == 4, c != 4); end
      if (c == 3) begin
        checks++; if (rd_addr !== 2'd2) begin errors++; $display("FAIL addi_rd: got %0d expected 2", rd_addr); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int writes;
    writes = 0;
    // INC rd=3, inc=3; RR rd=1 then waits on the bus with valid held high.
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = 9'b001_11_0011;
    @(posedge clk);
    #1;
    instr = 9'b010_01_0000;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (reg_we === 1'b1) writes++;
      if (c <= 3) begin
        checks++; if (alu_src !== 2'b00 || inc3 !== 3'd3) begin errors++; $display("FAIL inc_fields c%0d: got src=%b inc3=%0d expected 00/3", c, alu_src, inc3); end
        checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL inc_ready c%0d: got %b expected 0", c, instr_ready); end
      end
      if (c == 3) begin
        checks++; if (rd_addr !== 2'd3 || done !== 1'b1) begin errors++; $display("FAIL inc_wb: got rd=%0d done=%b expected 3/1", rd_addr, done); end
      end
    end
    checks++; if (writes != 1) begin errors++; $display("FAIL inc_writes: got %0d expected 1", writes); end
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_c4: got %b expected 1", instr_ready); end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = 9'h1FF;
    writes      = 0;
    for (int c = 5; c <= 8; c++) begin
      @(negedge clk);
      if (reg_we === 1'b1) writes++;
      if (c <= 7) begin
        checks++; if (alu_src !== 2'b10 || inc3 !== 3'd0 || rd_addr !== 2'd1) begin errors++; $display("FAIL rr_fields c%0d: got src=%b inc3=%0d rd=%0d expected 10/0/1", c, alu_src, inc3, rd_addr); end
      end
      if (c == 7) begin
        checks++; if (reg_we !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL rr_wb: got we=%b done=%b expected 1/1", reg_we, done); end
      end
    end
    checks++; if (writes != 1) begin errors++; $display("FAIL rr_writes: got %0d expected 1", writes); end
  endtask

  task automatic test_rep();
    int writes;
    writes = 0;
    issue(9'b011_01_0011);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (reg_we === 1'b1) writes++;
      checks++; if (reg_we !== (c == 3 || c == 5 || c == 7)) begin errors++; $display("FAIL rep_we c%0d: got %b expected %b", c, reg_we, c == 3 || c == 5 || c == 7); end
      checks++; if (done !== (c == 7)) begin errors++; $display("FAIL rep_done c%0d: got %b expected %b", c, done, c == 7); end
      if (c <= 7) begin
        checks++; if (alu_src !== 2'b00 || rd_addr !== 2'd1 || inc3 !== 3'd0) begin errors++; $display("FAIL rep_fields c%0d: got src=%b rd=%0d inc3=%0d expected 00/1/0", c, alu_src, rd_addr, inc3); end
      end
    end
    checks++; if (writes != 3) begin errors++; $display("FAIL rep_writes: got %0d expected 3", writes); end
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL rep_ready_c8: got %b expected 1", instr_ready); end
  endtask

  task automatic test_rep_zero();
    issue(9'b011_00_0000);
    @(negedge clk);
    checks++; if (done !== 1'b1 || reg_we !== 1'b0) begin errors++; $display("FAIL rep0_c1: got done=%b we=%b expected 1/0", done, reg_we); end
    @(negedge clk);
    checks++; if (instr_ready !== 1'b1 || done !== 1'b0 || reg_we !== 1'b0) begin errors++; $display("FAIL rep0_c2: got ready=%b done=%b we=%b expected 1/0/0", instr_ready, done, reg_we); end
  endtask

  task automatic test_illegal();
    logic exp_err;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    issue(9'b101_00_0000);
    @(negedge clk);
    checks++; if (done !== 1'b1 || err !== exp_err) begin errors++; $display("FAIL illegal_c1: got done=%b err=%b expected 1/%b", done, err, exp_err); end
    checks++; if (reg_we !== 1'b0 || alu_src !== 2'b10) begin errors++; $display("FAIL illegal_c1_we_src: got we=%b src=%b expected 0/10", reg_we, alu_src); end
    @(negedge clk);
    checks++; if (instr_ready !== 1'b1 || err !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL illegal_c2: got ready=%b err=%b done=%b expected 1/0/0", instr_ready, err, done); end
  endtask

  task automatic test_async_reset();
    issue(9'b000_10_0101);
    repeat (3) @(negedge clk);
    checks++; if (reg_we !== 1'b1) begin errors++; $display("FAIL areset_pre_we: got %b expected 1", reg_we); end
    #1;
    rst_n = 1'b0;
    #1;  // still well before the next rising edge
    checks++; if (reg_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL areset_flags: got we=%b done=%b busy=%b expected 0/0/0", reg_we, done, busy); end
    checks++; if (instr_ready !== 1'b1 || alu_src !== 2'b10 || imm4 !== 4'd0 || rd_addr !== 2'd0) begin errors++; $display("FAIL areset_fields: got ready=%b src=%b imm=%0d rd=%0d expected 1/10/0/0", instr_ready, alu_src, imm4, rd_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (reg_we !== 1'b0 || instr_ready !== 1'b1) begin errors++; $display("FAIL areset_after c%0d: got we=%b ready=%b expected 0/1", c, reg_we, instr_ready); end
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 9'd0;
    test_reset();
    test_addi();
    test_back_to_back();
    test_rep();
    test_rep_zero();
    test_illegal();
    test_async_reset();
    test_addi();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Multi-cycle sequencer that drives the ALU source select and operand fields of the R.O.E datapath. It accepts one 9-bit instruction at a time over a valid/ready handshake, steps DECODE → EXEC → WB, and issues alu_src, the 4-bit immediate, the 3-bit increment field, the destination register and the write enable. It also runs a hardware repeat (REP) that iterates an increment-by-one up to 15 times without refetching.

## Interface
- No parameters. Widths are fixed by the ISA: 9-bit instruction, 2-bit alu_src, 4-bit immediate, 3-bit increment.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- instr_valid  input  1  an instruction is presented on instr.
- instr  input  9  instruction fields:
  - [8:6] opcode.
  - [5:4] destination register.
  - [3:0] operand field.
- instr_ready  output  1  block can accept; high only in IDLE.
- alu_src  output  2  ALU operand select:
  - 00 = inc+1.
  - 01 = zero-extended immediate.
  - 10 = register read0.
- imm4  output  4  immediate operand sent to the ALU.
- inc3  output  3  increment field sent to the ALU.
- rd_addr  output  2  destination register.
- reg_we  output  1  register-file write enable.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse marking the end of an instruction.
- err  output  1  one-cycle pulse on an illegal opcode (only with the trap feature).

## Operation
- States: IDLE, DECODE, EXEC, WB. The state register is 2 bits.
- Accept: instr_valid & instr_ready in IDLE latches instr and moves to DECODE. instr_valid is ignored in every other state.
- DECODE, by opcode:
  - 000 ADDI: alu_src=01, imm4=instr[3:0].
  - 001 INC: alu_src=00, inc3=instr[2:0]. ALU operand is 1..8.
  - 010 RR: alu_src=10.
  - 011 REP: alu_src=00, inc3=0. Loads the 4-bit iteration counter with instr[3:0].
  - 1xx: illegal.
- In DECODE, every op except REP with count 0 and illegal opcodes goes to EXEC.
- EXEC: holds the operand selection and goes to WB.
- WB: reg_we=1 for one cycle with rd_addr = instr[5:4].
  - Non-REP: done=1, then IDLE.
  - REP: decrement the counter. If the counter was 1, assert done and go to IDLE; otherwise go to EXEC.
- REP with count 0: done pulses in the DECODE cycle, there is no reg_we, then IDLE.
- alu_src, imm4, inc3 and rd_addr are registered. They hold their value from DECODE through the last WB, and return to idle values in IDLE.
- alu_src never drives 11.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, instr_ready=1, alu_src=10, imm4=0, inc3=0, rd_addr=0.
  - reg_we=0, busy=0, done=0, err=0.
  - The repeat counter is cleared.
- Reset asserted mid-operation aborts the instruction. No further reg_we occurs.
- ADDI/INC/RR: accept at cycle 0, DECODE at 1, EXEC at 2, WB at 3 with reg_we and done. instr_ready=1 again at cycle 4.
  - Throughput is one instruction per 4 cycles.
- REP with n≥1: accept at 0, DECODE at 1, then EXEC/WB pairs. The k-th write lands at cycle 1+2k; done coincides with the n-th write at cycle 1+2n.
  - The total is n writes.
- done and reg_we are Moore outputs of WB (or of DECODE for the zero-count and illegal cases). They never depend combinationally on instr_valid.
- instr may change freely after acceptance; the latched copy is used.

## Configuration
- Macro: ALU_SEQ_ILLEGAL_TRAP_EN.
- Defined: an opcode 1xx pulses err and done together in DECODE. There is no reg_we, the state returns to IDLE, and alu_src stays 10.
- Undefined: opcode 1xx behaves as a NOP. done pulses in DECODE, and err is tied to 0.

## Test plan
- Async reset: assert rst_n=0 mid-WB of an ADDI → reg_we falls without waiting for clk. All outputs take reset values; instr_ready=1 after release.
- ADDI: instr=9'b000_10_0111 accepted at cycle 0 → cycles 1–3 show alu_src=01 and imm4=7. At cycle 3, reg_we=1, rd_addr=2 and done=1. At cycle 4, instr_ready=1.
- INC then RR back-to-back:
  - INC instr[2:0]=3 → alu_src=00, inc3=3, one write.
  - The following RR cannot be accepted before cycle 4, then shows alu_src=10 and one write.
- REP: instr=9'b011_01_0011 → exactly 3 reg_we pulses at cycles 3, 5 and 7, with rd_addr=1 and alu_src=00. done=1 only at cycle 7.
- REP with count 0: instr=9'b011_00_0000 → done at cycle 1, no reg_we, instr_ready=1 at cycle 2.
- Illegal opcode 9'b101_00_0000:
  - With ALU_SEQ_ILLEGAL_TRAP_EN: err=1 and done=1 at cycle 1, no reg_we.
  - Without the macro: done=1 at cycle 1 and err stays 0.
